// File: rtl/pwm_multi_channel_if.sv
// Register-access bus between the SPI peripheral's decoder and the PWM engine.
// The master issues write and read strobes. The slave returns read data one
// cycle after rd_en and holds it until the next read.
interface pwm_multi_channel_if;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM engine with a byte-wide register file.
// It provides a shared period counter with a prescaler, a per-channel duty value,
// output polarity control and per-channel output/PWM enables.
// PERIOD, PRESCALE and DUTY are double-buffered. A pending copy takes bus writes,
// and the active copy loads at the period wrap. While the engine is disabled, the
// active copy simply tracks the pending copy. Bus reads return the pending copy.
module pwm_multi_channel #(
  parameter int         NUM_CH       = 16,
  parameter logic [7:0] RESET_PERIOD = 8'd255,
  parameter logic [7:0] RESET_PRESC  = 8'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pwm_multi_channel_if.slave      bus,
  output logic [NUM_CH-1:0]       out,
  output logic                    period_start
);

  logic                   ctrl_en;
  logic                   ctrl_inv;
  logic [NUM_CH-1:0]      out_en;
  logic [NUM_CH-1:0]      pwm_en;

  logic [7:0]             period_pend, period_act, period_nxt;
  logic [7:0]             presc_pend,  presc_act,  presc_nxt;
  logic [NUM_CH-1:0][7:0] duty_pend,   duty_act,   duty_nxt;

  logic [7:0]             pre_cnt;
  logic [7:0]             cnt;
  logic                   tick;
  logic                   wrap;

  logic [7:0]             rd_nxt;
  logic [NUM_CH-1:0]      out_nxt;

  // Level of one channel for the current counter value.
  function automatic logic chan_level(input logic       oe,
                                      input logic       pe,
                                      input logic       en,
                                      input logic       inv,
                                      input logic [7:0] duty,
                                      input logic [7:0] cnt_v);
    logic lvl;
    if (!oe)      lvl = 1'b0;              // output disabled: hard low, polarity ignored
    else if (!pe) lvl = ~inv;              // static "on" level
    else if (en)  lvl = (duty > cnt_v) ^ inv;
    else          lvl = inv;               // PWM channel idle while engine stopped
    return lvl;
  endfunction

  assign tick = ctrl_en && (pre_cnt == presc_act);
  assign wrap = tick && (cnt == period_act);

  // Next pending values, including this cycle's write. The active copy loads from
  // these values, so a write in the wrap cycle takes effect in the new period.
  always_comb begin
    period_nxt = period_pend;
    presc_nxt  = presc_pend;
    duty_nxt   = duty_pend;
    if (bus.wr_en) begin
      if (bus.wr_addr == 7'h01) period_nxt = bus.wr_data;
      if (bus.wr_addr == 7'h02) presc_nxt  = bus.wr_data;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.wr_addr == 7'(32 + i)) duty_nxt[i] = bus.wr_data;
      end
    end
  end

  // Read mux over the pending/unshadowed registers; unmapped addresses read 0.
  always_comb begin
    rd_nxt = 8'h00;
    case (bus.rd_addr)
      7'h00:   rd_nxt = {6'b0, ctrl_inv, ctrl_en};
      7'h01:   rd_nxt = period_pend;
      7'h02:   rd_nxt = presc_pend;
      default: rd_nxt = 8'h00;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_addr == 7'(4 + i/8)) rd_nxt[3'(i%8)] = out_en[i];
      if (bus.rd_addr == 7'(8 + i/8)) rd_nxt[3'(i%8)] = pwm_en[i];
      if (bus.rd_addr == 7'(32 + i))  rd_nxt          = duty_pend[i];
    end
  end

  // Per-channel output levels from the current counter value.
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_nxt[i] = chan_level(out_en[i], pwm_en[i], ctrl_en, ctrl_inv, duty_act[i], cnt);
    end
  end

  // Unshadowed control and enable registers. They take effect on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en  <= 1'b0;
      ctrl_inv <= 1'b0;
      out_en   <= '0;
      pwm_en   <= '0;
    end else if (bus.wr_en) begin
      if (bus.wr_addr == 7'h00) begin
        ctrl_en  <= bus.wr_data[0];
        ctrl_inv <= bus.wr_data[1];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.wr_addr == 7'(4 + i/8)) out_en[i] <= bus.wr_data[3'(i%8)];
        if (bus.wr_addr == 7'(8 + i/8)) pwm_en[i] <= bus.wr_data[3'(i%8)];
      end
    end
  end

  // Pending copies capture every write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_pend <= RESET_PERIOD;
      presc_pend  <= RESET_PRESC;
      duty_pend   <= '0;
    end else begin
      period_pend <= period_nxt;
      presc_pend  <= presc_nxt;
      duty_pend   <= duty_nxt;
    end
  end

  // Active copies load at the period wrap, or continuously while stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act <= RESET_PERIOD;
      presc_act  <= RESET_PRESC;
      duty_act   <= '0;
    end else if (!ctrl_en || wrap) begin
      period_act <= period_nxt;
      presc_act  <= presc_nxt;
      duty_act   <= duty_nxt;
    end
  end

  // Prescaler and period counter. Both are held at 0 while stopped, so enabling
  // the engine always starts a clean period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 8'd0;
      cnt     <= 8'd0;
    end else if (!ctrl_en) begin
      pre_cnt <= 8'd0;
      cnt     <= 8'd0;
    end else if (tick) begin
      pre_cnt <= 8'd0;
      cnt     <= wrap ? 8'd0 : cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end

  // Output stage. The period_start pulse is aligned with the outputs' first
  // cycle at cnt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_nxt;
      period_start <= ctrl_en && (cnt == 8'd0) && (pre_cnt == 8'd0);
    end
  end

  // Read data register. It holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bus.rd_data <= 8'h00;
    else if (bus.rd_en) bus.rd_data <= rd_nxt;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel with four channels.
// All bus activity and sampling happen on the falling clock edge.
module tb_pwm_multi_channel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  out;
  logic        period_start;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  rd_val;
  logic [39:0] out_trace;
  logic [39:0] ps_trace;
  int          hi_cnt;
  int          ps_cnt;

  pwm_multi_channel_if bus ();

  pwm_multi_channel #(
    .NUM_CH       (4),
    .RESET_PERIOD (8'd255),
    .RESET_PRESC  (8'd0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  // Wait, with a bound, until period_start is high at a falling edge.
  task automatic wait_ps(input string tag);
    int n = 0;
    while (period_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 40'(period_start), 40'h1);
  endtask

  // Land on a period start that lies wholly after any preceding reprogramming.
  task automatic sync(input string tag);
    wait_ps(tag);
    @(negedge clk);
    wait_ps(tag);
  endtask

  // Record out[0] and period_start for n cycles, starting now. Optionally issue
  // one write during cycle index wr_at.
  task automatic capture(input int n, input int wr_at, input logic [6:0] a, input logic [7:0] d);
    out_trace = '0; ps_trace = '0; hi_cnt = 0; ps_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      out_trace[i] = out[0];
      ps_trace[i]  = period_start;
      hi_cnt += int'(out[0]);
      ps_cnt += int'(period_start);
      bus.wr_en = (i == wr_at); bus.wr_addr = a; bus.wr_data = d;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 7'h0; bus.wr_data = 8'h0;
    bus.rd_en = 1'b0; bus.rd_addr = 7'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", 40'(out), 40'h0);
    check("rst_ps", 40'(period_start), 40'h0);
    rst_n = 1'b1;
    rd(7'h01, rd_val); check("rst_period", 40'(rd_val), 40'hFF);
    rd(7'h02, rd_val); check("rst_presc", 40'(rd_val), 40'h00);
    rd(7'h20, rd_val); check("rst_duty0", 40'(rd_val), 40'h00);
    rd(7'h00, rd_val); check("rst_ctrl", 40'(rd_val), 40'h00);

    // Static outputs, enable masking beyond NUM_CH, unmapped addresses
    wr(7'h04, 8'hFF);
    wr(7'h08, 8'h01);
    @(negedge clk);
    check("static_out", 40'(out), 40'hE);
    rd(7'h04, rd_val); check("outen_mask", 40'(rd_val), 40'h0F);
    rd(7'h08, rd_val); check("pwmen_rd", 40'(rd_val), 40'h01);
    rd(7'h05, rd_val); check("outen_b1", 40'(rd_val), 40'h00);
    wr(7'h24, 8'h55);
    rd(7'h24, rd_val); check("duty_ch4", 40'(rd_val), 40'h00);
    rd(7'h03, rd_val); check("unmapped", 40'(rd_val), 40'h00);

    // Simultaneous read and write to PERIOD returns the old value
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 7'h01; bus.wr_data = 8'd9;
    bus.rd_en = 1'b1; bus.rd_addr = 7'h01;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("rdwr_old", 40'(bus.rd_data), 40'hFF);
    rd(7'h01, rd_val); check("period_new", 40'(rd_val), 40'h09);

    // Basic PWM: TOP=9, PRESC=0, DUTY0=3
    wr(7'h02, 8'd0);
    wr(7'h20, 8'd3);
    wr(7'h00, 8'h01);
    sync("basic_sync");
    capture(20, -1, 7'h0, 8'h0);
    check("basic_out", out_trace, 40'h01C07);
    check("basic_ps", ps_trace, 40'h00401);

    // Mid-period duty write is deferred to the next period
    sync("shadow_sync");
    capture(20, 1, 7'h20, 8'd7);
    check("shadow_out", out_trace, 40'h1FC07);
    rd(7'h20, rd_val); check("shadow_rd", 40'(rd_val), 40'h07);

    // Write in the wrap cycle is used immediately
    sync("wrap_sync");
    capture(20, 8, 7'h20, 8'd2);
    check("wrap_out", out_trace, 40'h00C7F);

    // Prescaler: PRESC=3, DUTY0=5 -> 20 high of 40
    wr(7'h02, 8'd3);
    wr(7'h20, 8'd5);
    sync("presc_sync");
    capture(40, -1, 7'h0, 8'h0);
    check("presc_out", out_trace, 40'h00000FFFFF);
    check("presc_hi", 40'(hi_cnt), 40'd20);
    check("presc_ps", 40'(ps_cnt), 40'd1);

    // DUTY=0: always low
    wr(7'h02, 8'd0);
    wr(7'h20, 8'd0);
    sync("d0_sync");
    capture(20, -1, 7'h0, 8'h0);
    check("duty0_out", out_trace, 40'h0);
    check("duty0_ps", ps_trace, 40'h00401);

    // DUTY > TOP: always high
    wr(7'h20, 8'd200);
    sync("d200_sync");
    capture(20, -1, 7'h0, 8'h0);
    check("duty200_out", out_trace, 40'hFFFFF);

    // Inverted polarity with DUTY0=3
    wr(7'h20, 8'd3);
    wr(7'h00, 8'h03);
    sync("inv_sync");
    capture(20, -1, 7'h0, 8'h0);
    check("inv_out", out_trace, 40'hFE3F8);
    check("inv_ps", ps_trace, 40'h00401);

    // OUT_EN=0 forces low regardless of polarity
    wr(7'h04, 8'h00);
    @(negedge clk);
    check("oe0_out", 40'(out), 40'h0);
    capture(20, -1, 7'h0, 8'h0);
    check("oe0_trace", out_trace, 40'h0);

    // Asynchronous reset in mid-period
    wr(7'h00, 8'h01);
    wr(7'h04, 8'h0F);
    wr(7'h20, 8'd200);
    sync("rst_sync");
    check("pre_rst_out", 40'(out), 40'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_out", 40'(out), 40'h0);
    check("async_ps", 40'(period_start), 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(7'h00, rd_val); check("post_ctrl", 40'(rd_val), 40'h00);
    rd(7'h20, rd_val); check("post_duty0", 40'(rd_val), 40'h00);
    rd(7'h01, rd_val); check("post_period", 40'(rd_val), 40'hFF);
    check("post_out", 40'(out), 40'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
